// File: rtl/keypad_scan_debounce.sv
`timescale 1ns/1ps
// keypad_scan_debounce: scans a 4x4 active-low keypad one column per SCAN_DIV
// clocks, debounces every key and emits serialized one-cycle press events.
module keypad_scan_debounce #(
    parameter int unsigned SCAN_DIV       = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       row_1,
    input  logic       row_2,
    input  logic       row_3,
    input  logic       row_4,
    output logic       col_1,
    output logic       col_2,
    output logic       col_3,
    output logic       col_4,
    output logic       keydown_num,
    output logic [3:0] num,
    output logic       keydown_start,
    output logic       keydown_confirm,
    output logic       keydown_clear,
    output logic       key_held
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_k;
    logic [3:0]       r_col_n;
    logic [15:0]      r_stable;
    logic [3:0]       r_cnt [16];
    logic [3:0]       r_pend;
    logic [1:0]       r_pend_col;
    logic [3:0]       r_num;
    logic             r_kd_num;
    logic             r_kd_start;
    logic             r_kd_conf;
    logic             r_kd_clr;
    logic             r_held;

    logic             w_sample;
    logic [3:0]       w_rows;
    logic [15:0]      w_stable_nxt;
    logic [3:0]       w_cnt_nxt [16];
    logic [3:0]       w_press;
    logic [3:0]       w_mask;
    logic [3:0]       w_pick;
    logic [1:0]       w_row;
    logic [1:0]       w_col;
    logic             w_fire;
    logic             w_is_digit;
    logic [3:0]       w_digit;

    assign w_sample = (r_div == DIV_W'(SCAN_DIV - 1));
    assign w_rows   = ~{row_4, row_3, row_2, row_1};

    // Key index is row*4 + column; only the driven column is updated.
    always_comb begin
        w_stable_nxt = r_stable;
        w_press      = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (w_sample && (2'(i % 4) == r_k)) begin
                if (w_rows[i / 4] == r_stable[i]) begin
                    w_cnt_nxt[i] = '0;
                end else if (r_cnt[i] == 4'(DEBOUNCE_SCANS - 1)) begin
                    w_cnt_nxt[i]    = '0;
                    w_stable_nxt[i] = ~r_stable[i];
                    if (!r_stable[i]) w_press[i / 4] = 1'b1;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 4'd1;
                end
            end
        end
    end

    // Fresh presses bypass the pending mask so the first pulse lands at T+1;
    // the mask always drains well before the next sample since SCAN_DIV >= 8.
    always_comb begin
        w_mask = r_pend | w_press;
        w_pick = w_mask & (~w_mask + 4'd1);
        w_fire = |w_mask;
        w_row  = 2'd0;
        for (int unsigned r = 4; r > 0; r--) begin
            if (w_mask[r-1]) w_row = 2'(r - 1);
        end
        w_col      = w_sample ? r_k : r_pend_col;
        w_is_digit = (w_col != 2'd3) && ((w_row != 2'd3) || (w_col == 2'd1));
        w_digit    = (w_row == 2'd3) ? 4'd0
                   : ({2'b00, w_row} * 4'd3 + {2'b00, w_col} + 4'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div      <= '0;
            r_k        <= '0;
            r_col_n    <= 4'b1110;
            r_stable   <= '0;
            r_cnt      <= '{default: '0};
            r_pend     <= '0;
            r_pend_col <= '0;
            r_num      <= '0;
            r_kd_num   <= 1'b0;
            r_kd_start <= 1'b0;
            r_kd_conf  <= 1'b0;
            r_kd_clr   <= 1'b0;
            r_held     <= 1'b0;
        end else begin
            r_div <= w_sample ? '0 : r_div + DIV_W'(1);
            if (w_sample) begin
                r_k        <= r_k + 2'd1;
                r_col_n    <= {r_col_n[2:0], r_col_n[3]};
                r_pend_col <= r_k;
            end
            r_stable   <= w_stable_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pend     <= w_mask & ~w_pick;
            r_held     <= |w_stable_nxt;
            r_kd_num   <= w_fire && w_is_digit;
            r_kd_start <= w_fire && (w_col == 2'd3) && (w_row == 2'd0);
            r_kd_conf  <= w_fire && (w_col == 2'd3) && (w_row == 2'd1);
            r_kd_clr   <= w_fire && (w_col == 2'd3) && (w_row == 2'd2);
            if (w_fire && w_is_digit) r_num <= w_digit;
        end
    end

    assign {col_4, col_3, col_2, col_1} = r_col_n;
    assign keydown_num     = r_kd_num;
    assign num             = r_num;
    assign keydown_start   = r_kd_start;
    assign keydown_confirm = r_kd_conf;
    assign keydown_clear   = r_kd_clr;
    assign key_held        = r_held;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
`timescale 1ns/1ps
// Bench for keypad_scan_debounce: keypad matrix model plus a scoreboard of
// expected press events with their exact cycles.
module tb_keypad_scan_debounce;

    localparam int unsigned SD   = 8;
    localparam int unsigned DB   = 3;
    localparam int unsigned SCAN = 4 * SD;
    localparam int EV_NUM   = 1;
    localparam int EV_START = 2;
    localparam int EV_CONF  = 3;
    localparam int EV_CLR   = 4;

    typedef struct {
        int          kind;
        int          num;
        int unsigned t;
    } evt_t;

    evt_t        q[$];
    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pressed = '0;
    logic [3:0]  rows_n;
    logic [3:0]  cols_low;
    logic        row_1, row_2, row_3, row_4;
    logic        col_1, col_2, col_3, col_4;
    logic        keydown_num, keydown_start, keydown_confirm, keydown_clear, key_held;
    logic [3:0]  num;
    int unsigned cyc;
    int          n_checks = 0;
    int          n_errors = 0;
    int          last_num = 0;

    keypad_scan_debounce #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk(clk), .rst_n(rst_n),
        .row_1(row_1), .row_2(row_2), .row_3(row_3), .row_4(row_4),
        .col_1(col_1), .col_2(col_2), .col_3(col_3), .col_4(col_4),
        .keydown_num(keydown_num), .num(num),
        .keydown_start(keydown_start), .keydown_confirm(keydown_confirm),
        .keydown_clear(keydown_clear), .key_held(key_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Pulled-up rows; a pressed key shorts its row to a column driven low.
    always_comb begin
        cols_low = ~{col_4, col_3, col_2, col_1};
        rows_n   = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4 + c] && cols_low[c]) rows_n[r] = 1'b0;
            end
        end
    end
    assign {row_4, row_3, row_2, row_1} = rows_n;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int key_kind(input int unsigned r, input int unsigned c);
        if (c == 3) begin
            if (r == 0) return EV_START;
            if (r == 1) return EV_CONF;
            if (r == 2) return EV_CLR;
            return 0;
        end
        if (r < 3) return EV_NUM;
        return (c == 1) ? EV_NUM : 0;
    endfunction

    function automatic int key_digit(input int unsigned r, input int unsigned c);
        return (r < 3) ? int'(r * 3 + c + 1) : 0;
    endfunction

    function automatic int unsigned first_sample(input int unsigned c, input int unsigned p);
        int unsigned t;
        t = p;
        while (!((t % SD == SD - 1) && ((t / SD) % 4 == c))) t++;
        return t;
    endfunction

    task automatic push_expect(input int unsigned idx, input int unsigned lower);
        int unsigned r;
        int unsigned c;
        evt_t        e;
        r = idx / 4;
        c = idx % 4;
        e.kind = key_kind(r, c);
        if (e.kind != 0) begin
            if (e.kind == EV_NUM) last_num = key_digit(r, c);
            e.num = last_num;
            e.t   = first_sample(c, cyc) + (DB - 1) * SCAN + 1 + lower;
            q.push_back(e);
        end
    endtask

    task automatic press(input int unsigned idx, input int unsigned lower);
        pressed[idx] = 1'b1;
        push_expect(idx, lower);
    endtask

    task automatic wait_cyc(input int unsigned n);
        int unsigned g;
        g = 0;
        while (cyc != n && g < 20000) begin
            @(negedge clk);
            g++;
        end
        if (cyc != n) check_eq("wait_cyc_timeout", int'(cyc), int'(n));
    endtask

    task automatic drain(input string tag);
        int unsigned g;
        g = 0;
        while (q.size() != 0 && g < 8 * SCAN) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        check_eq(tag, q.size(), 0);
    endtask

    task automatic release_wait(input int unsigned idx);
        int unsigned t;
        pressed[idx] = 1'b0;
        t = first_sample(idx % 4, cyc) + (DB - 1) * SCAN + 1;
        wait_cyc(t);
        check_eq("held_clear", int'(key_held), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        last_num = 0;
    endtask

    always @(negedge clk) begin
        int   cnt;
        int   kind;
        evt_t e;
        cnt = $countones({keydown_num, keydown_start, keydown_confirm, keydown_clear});
        if (rst_n && cnt != 0) begin
            check_eq("pulse_onehot", cnt, 1);
            kind = keydown_num ? EV_NUM : keydown_start ? EV_START
                 : keydown_confirm ? EV_CONF : EV_CLR;
            if (q.size() == 0) begin
                check_eq("unexpected_evt", kind, 0);
            end else begin
                e = q.pop_front();
                check_eq("evt_kind", kind, e.kind);
                check_eq("evt_num", int'(num), e.num);
                check_eq("evt_cycle", int'(cyc), int'(e.t));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        @(negedge clk);
        check_eq("init_cols", int'({col_1, col_2, col_3, col_4}), 'b0111);
        check_eq("init_pulses", int'({keydown_num, keydown_start, keydown_confirm, keydown_clear}), 0);
        check_eq("init_num", int'(num), 0);
        check_eq("init_held", int'(key_held), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single digit "5"
        press(5, 0);
        drain("drain_5");
        wait_cyc(100);
        check_eq("held_5", int'(key_held), 1);
        check_eq("num_5", int'(num), 5);
        wait_cyc(104);
        pressed[5] = 1'b0;
        wait_cyc(first_sample(1, 104) + (DB - 1) * SCAN);
        check_eq("held_5_last", int'(key_held), 1);
        wait_cyc(first_sample(1, 104) + (DB - 1) * SCAN + 1);
        check_eq("held_5_clear", int'(key_held), 0);
        wait_cyc(243);

        // Asynchronous reset mid-scan
        @(posedge clk);
        #3 rst_n = 1'b0;
        q.delete();
        #1;
        check_eq("rst_cols", int'({col_1, col_2, col_3, col_4}), 'b0111);
        check_eq("rst_pulses", int'({keydown_num, keydown_start, keydown_confirm, keydown_clear}), 0);
        check_eq("rst_num", int'(num), 0);
        check_eq("rst_held", int'(key_held), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        last_num = 0;
        wait_cyc(7);
        check_eq("cols_c7", int'({col_1, col_2, col_3, col_4}), 'b0111);
        wait_cyc(8);
        check_eq("cols_c8", int'({col_1, col_2, col_3, col_4}), 'b1011);

        // Bouncing "A": alternate scans, then held
        wait_cyc(32);
        for (int unsigned s = 0; s < 10; s++) begin
            pressed[3] = (s % 2 == 0);
            wait_cyc(64 + 32 * s);
        end
        press(3, 0);
        drain("drain_A");
        release_wait(3);

        // Same-column pair "2" and "8"
        press(1, 0);
        press(9, 1);
        drain("drain_pair");
        wait_cyc(cyc + 5);
        check_eq("num_hold_8", int'(num), 8);
        pressed[1] = 1'b0;
        release_wait(9);

        // Control keys B, C, then D (no event)
        press(7, 0);
        drain("drain_B");
        release_wait(7);
        press(11, 0);
        drain("drain_C");
        release_wait(11);
        pressed[15] = 1'b1;
        begin
            int unsigned t;
            t = first_sample(3, cyc) + (DB - 1) * SCAN;
            wait_cyc(t);
            check_eq("held_D_before", int'(key_held), 0);
            wait_cyc(t + 1);
            check_eq("held_D", int'(key_held), 1);
        end
        wait_cyc(cyc + SCAN);
        check_eq("num_after_D", int'(num), 8);
        release_wait(15);

        // Reset in the middle of debouncing "0"
        do_reset();
        pressed[13] = 1'b1;
        wait_cyc(50);
        do_reset();
        push_expect(13, 0);
        drain("drain_0");
        check_eq("num_0", int'(num), 0);
        check_eq("held_0", int'(key_held), 1);
        release_wait(13);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
